// File: rtl/uart_frame_rx_writer.sv
// Receives a framed RGB565 image from the UART RX FIFO, writes it to the frame buffer
// and answers each frame with an ACK/NAK byte into the UART TX FIFO.
module uart_frame_rx_writer #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    IMG_WIDTH      = 176,
   parameter int                    IMG_HEIGHT     = 240,
   parameter int                    FB_ADDR_WIDTH  = $clog2(IMG_WIDTH*IMG_HEIGHT),
   parameter int                    TIMEOUT_CYCLES = 12_500_000,
   parameter logic [DATA_WIDTH-1:0] SYNC0          = 8'hA5,
   parameter logic [DATA_WIDTH-1:0] SYNC1          = 8'h5A
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_WIDTH-1:0]     rx_data,
   input  logic                      rx_empty,
   output logic                      rx_pop,
   input  logic                      tx_full,
   output logic                      tx_push,
   output logic [DATA_WIDTH-1:0]     tx_data,
   output logic                      fb_we,
   output logic [FB_ADDR_WIDTH-1:0]  fb_wAddr,
   output logic [2*DATA_WIDTH-1:0]   fb_wData,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      err,
   output logic [1:0]                err_code
);

   localparam int                     TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]          TO_LAST   = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(IMG_WIDTH*IMG_HEIGHT - 1);
   localparam logic [DATA_WIDTH-1:0]  ACK_BYTE  = DATA_WIDTH'(8'h06);
   localparam logic [DATA_WIDTH-1:0]  NAK_BYTE  = DATA_WIDTH'(8'h15);

   typedef enum logic [2:0] {IDLE, HDR, PIX_HI, PIX_LO, CHK, RESP} state_t;

   state_t                    state, next;
   logic [TW-1:0]             tcnt;
   logic [FB_ADDR_WIDTH-1:0]  pix_cnt;
   logic [DATA_WIDTH-1:0]     checksum;
   logic [DATA_WIDTH-1:0]     hi_byte;

   logic                      pop, timed, timeout;
   logic                      clr_frame, pix_wr, load_resp, set_code;
   logic [DATA_WIDTH-1:0]     resp_byte;
   logic [1:0]                new_code;

   always_comb begin
      next       = state;
      clr_frame  = 1'b0;
      pix_wr     = 1'b0;
      load_resp  = 1'b0;
      set_code   = 1'b0;
      resp_byte  = ACK_BYTE;
      new_code   = 2'd0;
      frame_done = 1'b0;
      err        = 1'b0;
      tx_push    = 1'b0;
      timed      = (state == HDR) || (state == PIX_HI) || (state == PIX_LO) || (state == CHK);
      timeout    = (tcnt == TO_LAST);
      // Popping is gated by reset so the FIFO is never drained while held in reset.
      pop        = reset && !rx_empty && (state != RESP);

      case (state)
         IDLE: begin
            if (pop && rx_data == SYNC0) begin
               next      = HDR;
               clr_frame = 1'b1;
            end
         end
         HDR: begin
            if (pop) begin
               if (rx_data == SYNC1)      next = PIX_HI;
               else if (rx_data == SYNC0) next = HDR;
               else                       next = IDLE;
            end
         end
         PIX_HI: begin
            if (pop) next = PIX_LO;
         end
         PIX_LO: begin
            if (pop) begin
               pix_wr = 1'b1;
               next   = (pix_cnt == LAST_ADDR) ? CHK : PIX_HI;
            end
         end
         CHK: begin
            if (pop) begin
               next      = RESP;
               load_resp = 1'b1;
               if (rx_data == checksum) begin
                  frame_done = 1'b1;
               end else begin
                  resp_byte = NAK_BYTE;
                  err       = 1'b1;
                  set_code  = 1'b1;
                  new_code  = 2'd1;
               end
            end
         end
         RESP: begin
            if (!tx_full) begin
               tx_push = 1'b1;
               next    = IDLE;
            end
         end
         default: next = IDLE;
      endcase

      // A byte arriving on the last tolerated cycle still wins over the timeout.
      if (timed && !pop && timeout) begin
         next      = RESP;
         load_resp = 1'b1;
         resp_byte = NAK_BYTE;
         err       = 1'b1;
         set_code  = 1'b1;
         new_code  = 2'd2;
      end
   end

   assign rx_pop = pop;
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt     <= '0;
         pix_cnt  <= '0;
         checksum <= '0;
         hi_byte  <= '0;
         fb_we    <= 1'b0;
         fb_wAddr <= '0;
         fb_wData <= '0;
         tx_data  <= '0;
         err_code <= 2'd0;
      end else begin
         if (pop || !timed || next != state) tcnt <= '0;
         else                                tcnt <= tcnt + 1'b1;

         if (clr_frame) begin
            checksum <= '0;
            pix_cnt  <= '0;
            err_code <= 2'd0;
         end

         if (pop && (state == PIX_HI || state == PIX_LO)) checksum <= checksum + rx_data;
         if (pop && state == PIX_HI) hi_byte <= rx_data;

         fb_we <= pix_wr;
         if (pix_wr) begin
            fb_wAddr <= pix_cnt;
            fb_wData <= {hi_byte, rx_data};
            // Counter parks on the last address; the next header restarts it.
            if (pix_cnt != LAST_ADDR) pix_cnt <= pix_cnt + 1'b1;
         end

         if (load_resp) tx_data  <= resp_byte;
         if (set_code)  err_code <= new_code;
      end
   end

endmodule

// File: tb/tb_uart_frame_rx_writer.sv
// Directed bench for uart_frame_rx_writer on a 4x2 image with a 100-cycle timeout.
module tb_uart_frame_rx_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_empty;
   logic        rx_pop;
   logic        tx_full;
   logic        tx_push;
   logic [7:0]  tx_data;
   logic        fb_we;
   logic [2:0]  fb_wAddr;
   logic [15:0] fb_wData;
   logic        busy;
   logic        frame_done;
   logic        err;
   logic [1:0]  err_code;

   uart_frame_rx_writer #(
      .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2), .FB_ADDR_WIDTH(3),
      .TIMEOUT_CYCLES(100), .SYNC0(8'hA5), .SYNC1(8'h5A)
   ) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
      .tx_full(tx_full), .tx_push(tx_push), .tx_data(tx_data),
      .fb_we(fb_we), .fb_wAddr(fb_wAddr), .fb_wData(fb_wData),
      .busy(busy), .frame_done(frame_done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // First-word-fall-through RX FIFO model
   logic [7:0] mem [0:255];
   logic [7:0] rd = 8'd0;
   logic [7:0] wr = 8'd0;
   assign rx_empty = (rd == wr);
   assign rx_data  = mem[rd];
   always @(posedge clk) if (rx_pop) rd <= rd + 8'd1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder
   logic [2:0]  log_addr [0:255];
   logic [15:0] log_data [0:255];
   int wr_n = 0, push_n = 0, fd_n = 0, err_n = 0, overlap_n = 0;
   int last_pop = 0, push_cyc = 0;
   logic [7:0] push_data = 8'h00;
   always @(negedge clk) begin
      if (fb_we) begin
         log_addr[wr_n[7:0]] <= fb_wAddr;
         log_data[wr_n[7:0]] <= fb_wData;
         wr_n <= wr_n + 1;
      end
      if (rx_pop) last_pop <= cyc;
      if (tx_push) begin
         push_n    <= push_n + 1;
         push_data <= tx_data;
         push_cyc  <= cyc;
      end
      if (frame_done)        fd_n      <= fd_n + 1;
      if (err)               err_n     <= err_n + 1;
      if (tx_push && rx_pop) overlap_n <= overlap_n + 1;
   end

   int total = 0, passed = 0, failed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      mem[wr] = b;
      wr = wr + 8'd1;
   endtask

   task automatic put_frame(input logic [7:0] chk_byte);
      put(8'hA5);
      put(8'h5A);
      for (int i = 1; i <= 8; i++) begin
         put(8'h00);
         put(8'(i));
      end
      put(chk_byte);
   endtask

   task automatic wait_push(input int n0, input string tag);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (push_n > n0 && !busy) break;
      end
      @(negedge clk);
      chk({tag, "_push_count"}, push_n - n0, 1);
   endtask

   task automatic chk_writes(input int base, input string tag);
      chk({tag, "_write_count"}, wr_n - base, 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), {29'd0, log_addr[(base + i) % 256]}, i);
         chk($sformatf("%s_data%0d", tag, i), {16'd0, log_data[(base + i) % 256]}, i + 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   int base, p0, f0, e0, bad;

   initial begin
      reset   = 1'b0;
      tx_full = 1'b0;
      put(8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_pop", rx_pop, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_tx_push", tx_push, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_fb_waddr", fb_wAddr, 0);
      @(posedge clk); #1 reset = 1'b1;

      // Clean frame
      base = wr_n; p0 = push_n; f0 = fd_n; e0 = err_n;
      put_frame(8'h24);
      wait_push(p0, "clean");
      chk_writes(base, "clean");
      chk("clean_frame_done", fd_n - f0, 1);
      chk("clean_err", err_n - e0, 0);
      chk("clean_tx", push_data, 8'h06);
      chk("clean_busy", busy, 0);
      chk("clean_err_code", err_code, 0);

      // Bad checksum
      base = wr_n; p0 = push_n; f0 = fd_n; e0 = err_n;
      put_frame(8'h25);
      wait_push(p0, "badchk");
      chk_writes(base, "badchk");
      chk("badchk_err", err_n - e0, 1);
      chk("badchk_frame_done", fd_n - f0, 0);
      chk("badchk_err_code", err_code, 1);
      chk("badchk_tx", push_data, 8'h15);

      // Garbage prefix then valid frame
      base = wr_n; p0 = push_n; f0 = fd_n;
      put(8'h00); put(8'hA5);
      put_frame(8'h24);
      wait_push(p0, "garbage");
      chk_writes(base, "garbage");
      chk("garbage_frame_done", fd_n - f0, 1);
      chk("garbage_tx", push_data, 8'h06);
      chk("garbage_err_code", err_code, 0);

      // Stream stalls after 5 pixel bytes
      base = wr_n; p0 = push_n; e0 = err_n;
      put(8'hA5); put(8'h5A);
      put(8'h00); put(8'h01); put(8'h00); put(8'h02); put(8'h00);
      wait_push(p0, "timeout");
      chk("timeout_latency", push_cyc - last_pop, 100);
      chk("timeout_tx", push_data, 8'h15);
      chk("timeout_err_code", err_code, 2);
      chk("timeout_err", err_n - e0, 1);
      chk("timeout_writes", wr_n - base, 2);
      chk("timeout_busy", busy, 0);

      // TX FIFO full while responding, with RX bytes pending
      p0 = push_n;
      tx_full = 1'b1;
      put_frame(8'h24);
      put(8'h00); put(8'h11);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (frame_done) break;
      end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rx_pop || tx_push) bad++;
      end
      chk("txfull_held_quiet", bad, 0);
      chk("txfull_no_push", push_n - p0, 0);
      @(posedge clk); #1 tx_full = 1'b0;
      @(negedge clk);
      chk("txfull_push_now", tx_push, 1);
      chk("txfull_tx", tx_data, 8'h06);
      chk("no_pop_push_overlap", overlap_n, 0);

      // Reset in the middle of a frame
      repeat (5) @(negedge clk);
      base = wr_n;
      put(8'hA5); put(8'h5A);
      put(8'h00); put(8'h01); put(8'h00); put(8'h02); put(8'h00); put(8'h03);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (wr_n - base >= 3) break;
      end
      @(negedge clk);
      chk("midrst_writes", wr_n - base, 3);
      chk("midrst_busy_before", busy, 1);
      p0 = push_n;
      @(posedge clk); #1 reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_fb_we", fb_we, 0);
      chk("midrst_fb_wdata", fb_wData, 0);
      chk("midrst_tx_push", tx_push, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (150) @(negedge clk);
      chk("midrst_no_resp", push_n - p0, 0);
      base = wr_n; f0 = fd_n;
      put_frame(8'h24);
      wait_push(p0, "after_rst");
      chk_writes(base, "after_rst");
      chk("after_rst_frame_done", fd_n - f0, 1);
      chk("after_rst_tx", push_data, 8'h06);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
